// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
//
// Multi-digit hex display controller for active-low seven-segment banks.
// A load strobe captures a display value, a leading-zero-blanking enable and a
// per-digit blink mask. Every nibble is decoded to a full 0-F glyph set. Leading
// zeros are optionally blanked, and a free-running divider blinks the selected
// digits. All outputs are registered.
//
// Ports
//   clk         : system clock, all state updates on the rising edge
//   rst         : synchronous active-high reset, overrides load
//   load        : single-cycle capture strobe for value/lzb_en/blink_mask
//   value       : DIGITS nibbles, digit 0 at [3:0] (rightmost)
//   lzb_en      : leading-zero blanking enable, captured with load
//   blink_mask  : bit i=1 makes digit i blink, captured with load
//   hex_out     : digit i segments at [7i+6:7i], {g,f,e,d,c,b,a}, active-low
//   blink_phase : current blink phase, 1 = blinking digits blanked
// -----------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lzb_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  blink_phase
);

    localparam int              CNT_W     = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    // Capture registers
    logic [4*DIGITS-1:0] val_q;
    logic                lzb_q;
    logic [DIGITS-1:0]   bmask_q;

    // Blink divider
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic                cnt_wrap;

    // Output register
    logic [7*DIGITS-1:0] hex_q, hex_d;

    // Per-digit leading-zero blank flags
    logic [DIGITS-1:0]   lzb_blank;
    logic                zero_above;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Walk from the most significant digit downwards: digit i is blanked while
    // every nibble from the top down to i is zero. Digit 0 is never examined,
    // so an all-zero value still shows a single '0'.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lzb_blank  = '0;
        zero_above = lzb_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (val_q[4*i +: 4] == 4'h0);
            lzb_blank[i] = zero_above;
        end
    end

    always_comb begin
        hex_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (lzb_blank[i] || (bmask_q[i] && phase_q)) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_d[7*i +: 7] = seg_decode(val_q[4*i +: 4]);
            end
        end
    end

    assign cnt_wrap = (cnt_q == CNT_MAX);
    assign cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    assign phase_d  = phase_q ^ cnt_wrap;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            val_q   <= '0;
            lzb_q   <= 1'b0;
            bmask_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hex_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
            if (load) begin
                val_q   <= value;
                lzb_q   <= lzb_en;
                bmask_q <= blink_mask;
            end
        end
    end

    assign hex_out     = hex_q;
    assign blink_phase = phase_q;

endmodule
